// File: rtl/slot_game_ctrl_if.sv
// Button, reel and status signals between the slot-machine top level and its game controller.
// The master side drives the raw buttons and reel digits; the controller is the slave.
interface slot_game_ctrl_if;
  logic       C_IN;
  logic       GAME_START;
  logic       STOP_BTN;
  logic [3:0] REEL1;
  logic [3:0] REEL2;
  logic [3:0] REEL3;
  logic       STOP1;
  logic       STOP2;
  logic       STOP3;
  logic [6:0] CUR_COIN;
  logic [1:0] CUR_STATE;
  logic [1:0] WIN;

  modport master (
    output C_IN, GAME_START, STOP_BTN, REEL1, REEL2, REEL3,
    input  STOP1, STOP2, STOP3, CUR_COIN, CUR_STATE, WIN
  );

  modport slave (
    input  C_IN, GAME_START, STOP_BTN, REEL1, REEL2, REEL3,
    output STOP1, STOP2, STOP3, CUR_COIN, CUR_STATE, WIN
  );
endinterface

// File: rtl/slot_game_ctrl.sv
// Slot-machine game controller: button conditioning, credit bookkeeping, reel stop sequencing and payout.
// Optional macro SLOT_AUTO_STOP_EN adds an idle timeout that stops the next reel automatically.
module slot_game_ctrl #(
  parameter int COST          = 1,
  parameter int PAIR_PAY      = 5,
  parameter int JACKPOT_PAY   = 20,
  parameter int MAX_COIN      = 99,
  parameter int HOLD_CYC      = 50000000,
  parameter int AUTO_STOP_CYC = 100000000
) (
  input  logic            CLK,
  input  logic            RST,
  slot_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READY  = 2'd1,
    S_SPIN   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE    = 2'b00,
    WIN_PAIR    = 2'b01,
    WIN_JACKPOT = 2'b10
  } win_t;

  localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [6:0]        COST_7    = 7'(COST);
  localparam logic [7:0]        COST_8    = 8'(COST);
  localparam logic [7:0]        PAIR_8    = 8'(PAIR_PAY);
  localparam logic [7:0]        JACK_8    = 8'(JACKPOT_PAY);
  localparam logic [7:0]        MAX_8     = 8'(MAX_COIN);
  localparam logic [6:0]        MAX_7     = 7'(MAX_COIN);

  function automatic win_t classify(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if (a == b && b == c)             return WIN_JACKPOT;
    else if (a == b || b == c || a == c) return WIN_PAIR;
    else                              return WIN_NONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Button conditioning: bit 0 coin, bit 1 start, bit 2 stop.
  // ---------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] edge_q;
  logic       coin_ev;
  logic       start_ev;
  logic       stop_ev;

  assign btn_raw = {bus.STOP_BTN, bus.GAME_START, bus.C_IN};

  // NOTE: sequential blocks use non-blocking assignments so each stage sees the
  // previous stage's old value; blocking here would collapse the synchroniser.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign coin_ev  = sync2[0] & ~edge_q[0];
  assign start_ev = sync2[1] & ~edge_q[1];
  assign stop_ev  = sync2[2] & ~edge_q[2];

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [6:0]        cur_coin;
  logic [2:0]        stop_q;
  win_t              win_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        reel1_q;
  logic [3:0]        reel2_q;
  logic [3:0]        reel3_q;

  logic              auto_fire;
  logic              stop_hit;
  logic              start_go;
  logic              result_entry;

  assign start_go     = (state == S_READY) && start_ev && (cur_coin >= COST_7);
  assign result_entry = (state == S_RESULT) && (hold_cnt == '0);
  assign stop_hit     = (state == S_SPIN) && !stop_q[2] && (stop_ev || auto_fire);

`ifdef SLOT_AUTO_STOP_EN
  localparam int                AUTO_W    = $clog2(AUTO_STOP_CYC + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_STOP_CYC - 1);
  localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);
  logic [AUTO_W-1:0] auto_cnt;

  assign auto_fire = (state == S_SPIN) && !stop_q[2] && (auto_cnt == AUTO_LAST);

  // Any stop, manual or automatic, restarts the count; outside SPIN it is parked at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      auto_cnt <= '0;
    end else if (state != S_SPIN || stop_hit) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_ONE;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Credit arithmetic: coin, payout and debit land in one saturating update.
  // ---------------------------------------------------------------------------
  logic [7:0] payout;
  logic [7:0] debit;
  logic [7:0] credit_sum;
  logic [6:0] credit_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    payout = 8'd0;
    if (result_entry) begin
      case (classify(reel1_q, reel2_q, reel3_q))
        WIN_JACKPOT: payout = JACK_8;
        WIN_PAIR:    payout = PAIR_8;
        default:     payout = 8'd0;
      endcase
    end
    debit       = start_go ? COST_8 : 8'd0;
    credit_sum  = {1'b0, cur_coin} + {7'd0, coin_ev} + payout - debit;
    credit_next = (credit_sum > MAX_8) ? MAX_7 : credit_sum[6:0];
  end

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: the reel snapshot is ordinary flops, not a memory, so it is reset with
  // everything else; a mid-game reset then never leaves stale digits behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cur_coin <= '0;
      stop_q   <= '0;
      win_q    <= WIN_NONE;
      hold_cnt <= '0;
      reel1_q  <= '0;
      reel2_q  <= '0;
      reel3_q  <= '0;
    end else begin
      cur_coin <= credit_next;
      case (state)
        S_IDLE: begin
          if (cur_coin >= COST_7) state <= S_READY;
        end
        S_READY: begin
          if (cur_coin < COST_7) begin
            state <= S_IDLE;
          end else if (start_ev) begin
            state  <= S_SPIN;
            stop_q <= '0;
          end
        end
        S_SPIN: begin
          // The reels are frozen once STOP3 is up, so the live digits equal the snapshot.
          if (stop_q[2]) begin
            reel1_q  <= bus.REEL1;
            reel2_q  <= bus.REEL2;
            reel3_q  <= bus.REEL3;
            win_q    <= classify(bus.REEL1, bus.REEL2, bus.REEL3);
            hold_cnt <= '0;
            state    <= S_RESULT;
          end else if (stop_hit) begin
            stop_q <= {stop_q[1:0], 1'b1};
          end
        end
        S_RESULT: begin
          if (hold_cnt == HOLD_LAST) begin
            stop_q   <= '0;
            win_q    <= WIN_NONE;
            hold_cnt <= '0;
            state    <= (cur_coin >= COST_7) ? S_READY : S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.STOP1     = stop_q[0];
  assign bus.STOP2     = stop_q[1];
  assign bus.STOP3     = stop_q[2];
  assign bus.CUR_COIN  = cur_coin;
  assign bus.CUR_STATE = state;
  assign bus.WIN       = win_q;

endmodule
